// File: rtl/ss_pkg.sv
// Shared definitions for the ADMA copy-path beat buffer.
// Holds the controller state encoding, the command word index that arms
// a job, and the width of one buffered beat.
package ss_pkg;

  localparam int BEAT_W = 64;

  // Command word index of the destination descriptor (last word written).
  localparam logic [1:0] SS_ADR_DST_DESC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ss_state_e;

endpackage

// File: rtl/ss_fifo_ram.sv
// DEPTH x 64-bit storage for the copy-path buffer.
// Write is synchronous (one cycle), read is asynchronous (zero cycles).
// No flow control here: the controller decides when a write is legal.
module ss_fifo_ram
  import ss_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [BEAT_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [BEAT_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << AW;

  logic [BEAT_W-1:0] mem_q [DEPTH];

  // Capture one beat per accepted push.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ss_xfifo.sv
// Beat buffer between the source (read) and destination (write) sg engines.
// Latency: a beat pushed at edge N is visible first-word-fall-through at N+1.
// Backpressure: start/stop/end outputs throttle both engines from occupancy.
module ss_xfifo
  import ss_pkg::*;
#(
  parameter int AW    = 4,
  parameter int BURST = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          ss_we,
  input  logic [1:0]    ss_adr,
  input  logic          ss_done,
  input  logic [31:0]   src_dat_i,
  input  logic [31:0]   src_dat64_i,
  input  logic          src_xfer,
  input  logic          src_last,
  output logic          src_start,
  output logic          src_stop,
  output logic          src_end,
  output logic [31:0]   dst_dat_o,
  output logic [31:0]   dst_dat64_o,
  input  logic          dst_xfer,
  input  logic          dst_last,
  output logic          dst_start,
  output logic          dst_stop,
  output logic          dst_end,
  output logic [AW:0]   fifo_cnt,
  output logic [1:0]    fifo_err,
  output logic          f_done
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(1 << AW);
  localparam logic [AW:0] BURST_C = (AW+1)'(BURST);

  ss_state_e   state_q, state_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d, cnt_nxt;
  logic          eof_q, eof_d, dlast_q, dlast_d;
  logic [1:0]    err_q, err_d;
  logic          src_start_q, src_start_d, dst_start_q, dst_start_d;
  logic          src_end_q, src_end_d, dst_end_q, dst_end_d;
  logic          act, in_rd_q, in_rd_d, arm;
  logic          full, empty, push_ok, pop_ok, ovf, udf;
  logic [BEAT_W-1:0] head;

  assign arm   = (state_q == ST_IDLE) && ss_we && (ss_adr == SS_ADR_DST_DESC) && !ss_done;
  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);
  // A simultaneous pop frees the slot a full push needs, and a simultaneous
  // push supplies the beat an empty pop takes, so neither is an error.
  assign push_ok = act && src_xfer && (!full  || dst_xfer);
  assign pop_ok  = act && dst_xfer && (!empty || src_xfer);
  assign ovf     = act && src_xfer && full  && !dst_xfer;
  assign udf     = act && dst_xfer && empty && !src_xfer;

  // Occupancy after this cycle's accepted push/pop.
  always_comb begin
    cnt_nxt = cnt_q;
    if (push_ok && !pop_ok)      cnt_nxt = cnt_q + 1'b1;
    else if (pop_ok && !push_ok) cnt_nxt = cnt_q - 1'b1;
  end

  // Controller state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state: retire wins everywhere; destination last ends the job early.
  always_comb begin
    state_d = state_q;
    if (ss_done) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (arm) state_d = ST_RUN;
        ST_RUN: begin
          if (dst_xfer && dst_last)      state_d = ST_DONE;
          else if (src_xfer && src_last) state_d = ST_DRAIN;
        end
        ST_DRAIN: if (cnt_nxt == '0 || (dst_xfer && dst_last)) state_d = ST_DONE;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State-derived qualifiers and the done flag.
  always_comb begin
    act     = (state_q != ST_IDLE);
    in_rd_q = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    in_rd_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    f_done  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  end

  // Datapath next-state: arming starts a job from a clean buffer.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    eof_d   = eof_q;
    err_d   = err_q;
    dlast_d = dlast_q;
    if (arm) begin
      wp_d    = '0;
      rp_d    = '0;
      cnt_d   = '0;
      eof_d   = 1'b0;
      err_d   = 2'b00;
      dlast_d = 1'b0;
    end else begin
      if (push_ok) wp_d = wp_q + 1'b1;
      if (pop_ok)  rp_d = rp_q + 1'b1;
      cnt_d = cnt_nxt;
      if (act && src_xfer && src_last) eof_d = 1'b1;
      if (act && dst_xfer && dst_last) dlast_d = 1'b1;
      if (ovf) err_d[0] = 1'b1;
      if (udf) err_d[1] = 1'b1;
    end
  end

  // Engine handshakes. Starts drop on the first beat and re-arm only in a
  // gap; ends are sticky for the life of the job.
  always_comb begin
    src_start_d = (state_q == ST_RUN) && (state_d == ST_RUN) && !eof_q && !src_xfer &&
                  (src_start_q || ((DEPTH_C - cnt_q) >= BURST_C));
    dst_start_d = in_rd_q && in_rd_d && !dst_xfer &&
                  (dst_start_q || (cnt_q >= BURST_C) || (eof_q && cnt_q != '0));
    src_end_d   = (state_d != ST_IDLE) &&
                  (src_end_q || (act && dst_xfer && dst_last && !eof_q));
    dst_end_d   = (state_d != ST_IDLE) &&
                  (dst_end_q || (act && eof_q && cnt_q == '0 && !dlast_q &&
                                 !(dst_xfer && dst_last)));
  end

  // Registered pointers, occupancy, job flags and handshakes.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      eof_q       <= 1'b0;
      dlast_q     <= 1'b0;
      err_q       <= 2'b00;
      src_start_q <= 1'b0;
      dst_start_q <= 1'b0;
      src_end_q   <= 1'b0;
      dst_end_q   <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      eof_q       <= eof_d;
      dlast_q     <= dlast_d;
      err_q       <= err_d;
      src_start_q <= src_start_d;
      dst_start_q <= dst_start_d;
      src_end_q   <= src_end_d;
      dst_end_q   <= dst_end_d;
    end
  end

  ss_fifo_ram #(.AW(AW)) u_ram (
    .clk_i   (wb_clk_i),
    .we_i    (push_ok),
    .waddr_i (wp_q),
    .wdata_i ({src_dat64_i, src_dat_i}),
    .raddr_i (rp_q),
    .rdata_o (head)
  );

  // Stops qualify the beat being acknowledged this very cycle.
  assign src_stop    = act && src_xfer && (cnt_nxt == DEPTH_C);
  assign dst_stop    = act && dst_xfer && (cnt_nxt == '0) && !dst_last;
  assign src_start   = src_start_q;
  assign dst_start   = dst_start_q;
  assign src_end     = src_end_q;
  assign dst_end     = dst_end_q;
  assign fifo_cnt    = cnt_q;
  assign fifo_err    = err_q;
  assign dst_dat_o   = head[31:0];
  assign dst_dat64_o = head[63:32];

endmodule

// File: tb/tb_ss_xfifo.sv
// Directed bench for ss_xfifo: a cycle table for the basic job and the
// early-destination-last job, then hand sequences for full/overflow,
// full-rate wrap, short job with missing dst_last, and async reset.
module tb_ss_xfifo;

  logic        clk, rst;
  logic        ss_we, ss_done;
  logic [1:0]  ss_adr;
  logic [31:0] src_dat_i, src_dat64_i, dst_dat_o, dst_dat64_o;
  logic        src_xfer, src_last, src_start, src_stop, src_end;
  logic        dst_xfer, dst_last, dst_start, dst_stop, dst_end;
  logic [4:0]  fifo_cnt;
  logic [1:0]  fifo_err;
  logic        f_done;

  int n_cmp = 0;
  int n_bad = 0;

  ss_xfifo #(.AW(4), .BURST(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .ss_we(ss_we), .ss_adr(ss_adr), .ss_done(ss_done),
    .src_dat_i(src_dat_i), .src_dat64_i(src_dat64_i),
    .src_xfer(src_xfer), .src_last(src_last),
    .src_start(src_start), .src_stop(src_stop), .src_end(src_end),
    .dst_dat_o(dst_dat_o), .dst_dat64_o(dst_dat64_o),
    .dst_xfer(dst_xfer), .dst_last(dst_last),
    .dst_start(dst_start), .dst_stop(dst_stop), .dst_end(dst_end),
    .fifo_cnt(fifo_cnt), .fifo_err(fifo_err), .f_done(f_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] lo(input int k);
    return 32'h1000_0000 | 32'(k);
  endfunction
  function automatic logic [31:0] hi(input int k);
    return 32'hC000_0000 | (32'(k) << 4);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic sx, input logic sl, input int sk,
                       input logic dx, input logic dl);
    ss_we = 1'b0; ss_adr = 2'd0; ss_done = 1'b0;
    src_xfer = sx; src_last = sl; src_dat_i = lo(sk); src_dat64_i = hi(sk);
    dst_xfer = dx; dst_last = dl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic chk_head(input string nm, input int k);
    chk({nm, "_lo"}, dst_dat_o, lo(k));
    chk({nm, "_hi"}, dst_dat64_o, hi(k));
  endtask

  // Arm cycle followed by one idle cycle so src_start can come up.
  task automatic arm_job();
    idle(); ss_we = 1'b1; ss_adr = 2'd3; nxt();
    idle(); nxt();
  endtask

  task automatic retire();
    idle(); ss_done = 1'b1; nxt();
    idle();
  endtask

  typedef struct {
    logic we; logic [1:0] adr; logic done;
    logic sx; logic sl; int sk; logic dx; logic dl;
    int   e_cnt; logic e_fd, e_ss, e_ds, e_sp, e_dp, e_se, e_de;
    logic [1:0] e_err; int e_hd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(input logic we, input logic [1:0] adr, input logic done,
                             input logic sx, input logic sl, input int sk,
                             input logic dx, input logic dl,
                             input int cnt, input logic fd, input logic ss, input logic ds,
                             input logic sp, input logic dp, input logic se, input logic de,
                             input logic [1:0] err, input int hd);
    vec_t r;
    r.we = we; r.adr = adr; r.done = done; r.sx = sx; r.sl = sl; r.sk = sk;
    r.dx = dx; r.dl = dl; r.e_cnt = cnt; r.e_fd = fd; r.e_ss = ss; r.e_ds = ds;
    r.e_sp = sp; r.e_dp = dp; r.e_se = se; r.e_de = de; r.e_err = err; r.e_hd = hd;
    return r;
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    #2;
    chk("rst_f_done", f_done, 1'b1);
    chk("rst_cnt", fifo_cnt, 5'd0);
    chk("rst_err", fifo_err, 2'b00);
    chk("rst_starts", {src_start, dst_start}, 2'b00);
    chk("rst_stops", {src_stop, dst_stop}, 2'b00);
    chk("rst_ends", {src_end, dst_end}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- Table: 8-beat job, then a job ended early by dst_last ----
    //       we adr dn sx sl sk dx dl | cnt fd ss ds sp dp se de err hd
    vq.push_back(v(1, 3, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 2'b00, -1));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 2'b00, -1));
    vq.push_back(v(0, 0, 0, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0, 2'b00, -1));
    for (int k = 1; k < 8; k++)
      vq.push_back(v(0, 0, 0, 1, (k == 7), k, 0, 0, k, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   8, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 0,   8, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0));
    for (int k = 1; k < 7; k++)
      vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 8 - k, 0, 0, 0, 0, 0, 0, 0, 2'b00, k));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 7));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 2'b00, -1));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 2'b00, -1));
    vq.push_back(v(0, 0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 2'b00, -1));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 2'b00, -1));
    vq.push_back(v(1, 3, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 2'b00, -1));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 2'b00, -1));
    vq.push_back(v(0, 0, 0, 1, 0, 32, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0, 2'b00, -1));
    vq.push_back(v(0, 0, 0, 1, 0, 33, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 1,   2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 1, 0, 2'b00, 33));
    vq.push_back(v(0, 0, 1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 1, 0, 2'b00, 33));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 2'b00, -1));

    foreach (vq[i]) begin
      drive(vq[i].sx, vq[i].sl, vq[i].sk, vq[i].dx, vq[i].dl);
      ss_we = vq[i].we; ss_adr = vq[i].adr; ss_done = vq[i].done;
      @(negedge clk);
      chk($sformatf("v%0d_cnt", i), fifo_cnt, 5'(vq[i].e_cnt));
      chk($sformatf("v%0d_f_done", i), f_done, vq[i].e_fd);
      chk($sformatf("v%0d_src_start", i), src_start, vq[i].e_ss);
      chk($sformatf("v%0d_dst_start", i), dst_start, vq[i].e_ds);
      chk($sformatf("v%0d_src_stop", i), src_stop, vq[i].e_sp);
      chk($sformatf("v%0d_dst_stop", i), dst_stop, vq[i].e_dp);
      chk($sformatf("v%0d_src_end", i), src_end, vq[i].e_se);
      chk($sformatf("v%0d_dst_end", i), dst_end, vq[i].e_de);
      chk($sformatf("v%0d_err", i), fifo_err, vq[i].e_err);
      if (vq[i].e_hd >= 0) chk_head($sformatf("v%0d_head", i), vq[i].e_hd);
      nxt();
    end

    // ---- Fill to 16, then overflow ----
    arm_job();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 64 + i, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("fill%0d_src_stop", i), src_stop, (i == 15));
      nxt();
    end
    idle();
    @(negedge clk);
    chk("full_cnt", fifo_cnt, 5'd16);
    chk("full_err", fifo_err, 2'b00);
    nxt();
    drive(1'b1, 1'b0, 153, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovf_src_stop", src_stop, 1'b1);
    nxt();
    idle();
    @(negedge clk);
    chk("ovf_err", fifo_err, 2'b01);
    chk("ovf_cnt", fifo_cnt, 5'd16);
    chk_head("ovf_head", 64);
    nxt();
    retire();

    // ---- Full-rate push+pop while full, pointers wrap ----
    arm_job();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 256 + i, 1'b0, 1'b0);
      nxt();
    end
    for (int j = 0; j < 20; j++) begin
      drive(1'b1, 1'b0, 272 + j, 1'b1, 1'b0);
      @(negedge clk);
      chk_head($sformatf("wrap%0d_head", j), 256 + j);
      chk($sformatf("wrap%0d_cnt", j), fifo_cnt, 5'd16);
      nxt();
    end
    idle();
    @(negedge clk);
    chk("wrap_cnt", fifo_cnt, 5'd16);
    chk("wrap_err", fifo_err, 2'b00);
    nxt();
    for (int j = 0; j < 16; j++) begin
      drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
      @(negedge clk);
      chk_head($sformatf("drain%0d_head", j), 276 + j);
      chk($sformatf("drain%0d_dst_stop", j), dst_stop, (j == 15));
      nxt();
    end
    retire();

    // ---- Short job: eof starts destination, missing dst_last -> dst_end ----
    arm_job();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, (i == 2), 48 + i, 1'b0, 1'b0);
      nxt();
    end
    idle();
    @(negedge clk);
    chk("short_cnt", fifo_cnt, 5'd3);
    chk("short_dst_start_early", dst_start, 1'b0);
    nxt();
    @(negedge clk);
    chk("short_dst_start", dst_start, 1'b1);
    nxt();
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
      @(negedge clk);
      chk_head($sformatf("short%0d_head", j), 48 + j);
      chk($sformatf("short%0d_dst_stop", j), dst_stop, (j == 2));
      nxt();
    end
    idle();
    @(negedge clk);
    chk("short_f_done", f_done, 1'b1);
    nxt();
    @(negedge clk);
    chk("short_dst_end", dst_end, 1'b1);
    nxt();
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
    nxt();
    idle();
    @(negedge clk);
    chk("udf_err", fifo_err, 2'b10);
    chk("udf_cnt", fifo_cnt, 5'd0);
    chk("udf_dst_end_held", dst_end, 1'b1);
    nxt();
    retire();
    @(negedge clk);
    chk("retire_dst_end", dst_end, 1'b0);
    nxt();

    // ---- Asynchronous reset mid-job ----
    arm_job();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 80 + i, 1'b0, 1'b0);
      nxt();
    end
    drive(1'b1, 1'b0, 85, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_cnt", fifo_cnt, 5'd5);
    chk("pre_rst_f_done", f_done, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst_cnt", fifo_cnt, 5'd0);
    chk("arst_f_done", f_done, 1'b1);
    chk("arst_starts", {src_start, dst_start}, 2'b00);
    chk("arst_stops", {src_stop, dst_stop}, 2'b00);
    chk("arst_err", fifo_err, 2'b00);
    nxt();
    idle();
    rst = 1'b0;
    nxt();
    @(negedge clk);
    chk("post_rst_f_done", f_done, 1'b1);
    chk("post_rst_cnt", fifo_cnt, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
